// File: rtl/rom_scan_pkg.sv
// Shared types and constants for the ROM scan controller and its address counter.
package rom_scan_pkg;

  localparam int ADDR_W = 4;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Index of the last sample for a requested length; 0 and anything past 16 mean a full scan.
  function automatic logic [ADDR_W-1:0] last_index(input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] w_m1;
    w_m1 = len - 1'b1;
    if ((len == '0) || (len > CNT_W'(WORD_W))) begin
      return ADDR_W'(WORD_W - 1);
    end
    return w_m1[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/addr_counter_4b.sv
// Loadable 4-bit wrap-around counter; load has priority over enable.
module addr_counter_4b
  import rom_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_count
);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rom_scan_controller.sv
// Sequences consecutive addresses into a 16x1 ROM, packs the sampled bits with a
// population count, and holds the result for a downstream valid/ready consumer.
module rom_scan_controller
  import rom_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  length,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              rom_data,
  output logic              busy,
  output logic [WORD_W-1:0] word_out,
  output logic [CNT_W-1:0]  ones_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        o_dbg_state
);

  // Handshake: out_valid rises once the last sample lands and stays high, with
  // word_out/ones_count frozen, until the first edge where out_ready is also high;
  // the transfer completes on that edge and the block returns to IDLE.

  state_t            r_state;
  logic              r_busy;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_ones;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_last_k;

  logic w_load;
  logic w_step;

  assign w_load = (r_state == IDLE) && start;
  assign w_step = (r_state == SCAN);

  addr_counter_4b u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_step),
    .i_load_val (start_addr),
    .o_count    (rom_address)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_word      <= '0;
      r_ones      <= '0;
      r_k         <= '0;
      r_last_k    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_word   <= '0;
            r_ones   <= '0;
            r_k      <= '0;
            r_last_k <= last_index(length);
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          r_word[r_k] <= rom_data;
          r_ones      <= r_ones + {{(CNT_W-1){1'b0}}, rom_data};
          r_k         <= r_k + 1'b1;
          if (r_k == r_last_k) begin
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          // A start seen together with out_ready is dropped, not queued.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign word_out    = r_word;
  assign ones_count  = r_ones;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rom_scan_controller.sv
// Bench for rom_scan_controller with a behavioural 16x1 ROM (contents 0xE7A5).
module tb_rom_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  start_addr;
  logic [4:0]  length;
  logic [3:0]  rom_address;
  logic        rom_data;
  logic        busy;
  logic [15:0] word_out;
  logic [4:0]  ones_count;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  o_dbg_state;

  logic [15:0] rom_word;
  logic [20:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  rom_scan_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .busy        (busy),
    .word_out    (word_out),
    .ones_count  (ones_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rom_data = rom_word[rom_address];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference result for a scan: {ones, word}
  function automatic logic [20:0] model(input logic [3:0] a, input logic [4:0] len);
    int          l;
    logic [15:0] w;
    logic [4:0]  c;
    logic [3:0]  ad;
    l = (len == 0) ? 16 : int'(len);
    w = '0;
    c = '0;
    for (int k = 0; k < l; k++) begin
      ad   = a + 4'(k);
      w[k] = rom_word[ad];
      c    = c + {4'b0, rom_word[ad]};
    end
    return {c, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [3:0] a, input logic [4:0] len,
                          input int hold_cycles, input bit inject_start);
    int          l;
    int          n;
    logic [20:0] exp;
    l = (len == 0) ? 16 : int'(len);
    start      = 1'b1;
    start_addr = a;
    length     = len;
    exp_q.push_back(model(a, len));
    tick();
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 1);
    check("first_addr", {28'b0, rom_address}, {28'b0, a});
    n = 0;
    while (!out_valid && n < 40) begin
      if (inject_start && n == 0) begin
        start      = 1'b1;
        start_addr = 4'd9;
        length     = 5'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", n, l);
    exp = exp_q.pop_front();
    check("word_out", {16'b0, word_out}, {16'b0, exp[15:0]});
    check("ones_count", {27'b0, ones_count}, {27'b0, exp[20:16]});
    check("final_addr", {28'b0, rom_address}, {28'b0, a + 4'(l)});
    check("hold_state", {30'b0, o_dbg_state}, 2);
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check("valid_held", {31'b0, out_valid}, 1);
      check("word_stable", {16'b0, word_out}, {16'b0, exp[15:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_fall", {31'b0, out_valid}, 0);
    check("busy_fall", {31'b0, busy}, 0);
    check("word_kept", {16'b0, word_out}, {16'b0, exp[15:0]});
    check("addr_kept", {28'b0, rom_address}, {28'b0, a + 4'(l)});
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rom_word   = 16'hE7A5;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_addr", {28'b0, rom_address}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_word", {16'b0, word_out}, 0);
    check("rst_ones", {27'b0, ones_count}, 0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_state", {30'b0, o_dbg_state}, 0);

    // Directed scenarios
    run_scan(4'd0, 5'd0, 0, 1'b0);
    check("full_word_const", {16'b0, word_out}, 32'h0000E7A5);
    check("full_ones_const", {27'b0, ones_count}, 10);
    tick();
    run_scan(4'd14, 5'd4, 0, 1'b0);
    check("wrap_word_const", {16'b0, word_out}, 32'h7);
    check("wrap_addr_const", {28'b0, rom_address}, 2);
    tick();
    run_scan(4'd3, 5'd1, 5, 1'b0);
    tick();
    run_scan(4'd5, 5'd3, 0, 1'b0);
    tick();
    run_scan(4'd5, 5'd3, 1, 1'b1);
    check("ign_word_const", {16'b0, word_out}, 32'h5);
    check("ign_ones_const", {27'b0, ones_count}, 2);
    tick();

    // start together with out_ready in HOLD is not honoured
    start = 1'b1; start_addr = 4'd2; length = 5'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    check("hs_hold", {31'b0, out_valid}, 1);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("hs_idle_busy", {31'b0, busy}, 0);
    tick();
    check("hs_no_restart", {31'b0, busy}, 0);

    // Async reset during a full scan
    start = 1'b1; start_addr = 4'd0; length = 5'd0;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_addr", {28'b0, rom_address}, 0);
    check("ar_busy", {31'b0, busy}, 0);
    check("ar_word", {16'b0, word_out}, 0);
    check("ar_ones", {27'b0, ones_count}, 0);
    check("ar_valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_scan(4'd8, 5'd3, 0, 1'b0);
    check("ar_word_const", {16'b0, word_out}, 32'h7);

    // Random scans
    for (int i = 0; i < 12; i++) begin
      tick();
      run_scan(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
